// File: rtl/sw8_gpio_in.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sw8_gpio_in : 8-bit debounced switch input, sticky edge flags, read-clear |
// | Optional macro SW8_GPIO_IRQ_EN adds the registered interrupt. Rev 1.0     |
// +--------------------------------------------------------------------------+
module sw8_gpio_in #(
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         EDGE_MODE       = 0,
  parameter logic [7:0] IRQ_MASK        = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SW8_GPIO_I_pin,
  input  logic       RD_STB,
  output logic [7:0] DATA_O,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID,
  output logic       IRQ_O
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_meta;
  logic [7:0] r_sync;
  logic [7:0] r_flags;
  logic [7:0] w_toggle;
  logic [7:0] w_edge;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_meta <= 8'h00;
      r_sync <= 8'h00;
    end else begin
      r_meta <= SW8_GPIO_I_pin;
      r_sync <= r_meta;
    end
  end

  generate
    for (genvar i = 0; i < 8; i++) begin : g_bit
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;

      assign w_diff      = r_sync[i] ^ DATA_O[i];
      assign w_toggle[i] = w_diff && (r_cnt == CNT_LAST);

      always_ff @(posedge CLK) begin
        if (RESET || !w_diff || w_toggle[i]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_O <= 8'h00;
    end else begin
      DATA_O <= DATA_O ^ w_toggle;
    end
  end

  // Edge type is judged from the pre-toggle state of DATA_O.
  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign w_edge = w_toggle & ~DATA_O;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign w_edge = w_toggle & DATA_O;
    end else begin : g_both
      assign w_edge = w_toggle;
    end
  endgenerate

  // A read clears exactly the flags it returns; an edge on the same cycle survives.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags  <= 8'h00;
      RD_DATA  <= 8'h00;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_STB;
      if (RD_STB) begin
        RD_DATA <= r_flags;
      end
      r_flags <= (RD_STB ? 8'h00 : r_flags) | w_edge;
    end
  end

`ifdef SW8_GPIO_IRQ_EN
  logic r_irq;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_flags & IRQ_MASK);
    end
  end

  assign IRQ_O = r_irq;
`else
  // Folds to a constant zero.
  assign IRQ_O = &{1'b0, IRQ_MASK};
`endif

endmodule
`default_nettype wire
